// File: rtl/rx_display_scheduler_pkg.sv
// Shared definitions for the IrDA receive-path display scheduler:
// FSM encoding, blank display value and default dwell for a 50 MHz clock.
package rx_display_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_SHOW   = 2'd1,
        ST_FROZEN = 2'd2
    } disp_state_e;

    localparam logic [7:0] SEG_BLANK   = 8'h00;
    localparam int         DWELL_50MHZ = 50_000_000;

endpackage

// File: rtl/rx_history_buf.sv
// Circular history of received bytes with an age-indexed read port
// (age 0 = most recently written entry).
module rx_history_buf
    import rx_display_scheduler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             i_clk_sys,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_wr_en,
    input  logic [7:0]       i_wr_data,
    input  logic [IDX_W-1:0] i_rd_age,
    output logic [7:0]       o_rd_data,
    output logic [IDX_W:0]   o_count,
    output logic             o_overflow
);

    localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

    logic [7:0]       r_mem [DEPTH];
    logic [IDX_W-1:0] r_wr_ptr;
    logic [IDX_W:0]   r_count;
    logic             r_overflow;
    logic [IDX_W-1:0] w_rd_slot;
    logic             w_full;

    assign w_full = (r_count == FULL_COUNT);

    // Contents need no reset: only slots below r_count are ever read.
    always_ff @(posedge i_clk_sys) begin
        if (i_wr_en && !i_clear) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_wr_en) begin
            r_wr_ptr <= r_wr_ptr + IDX_W'(1);
            if (w_full) begin
                r_overflow <= 1'b1;
            end else begin
                r_count <= r_count + (IDX_W+1)'(1);
            end
        end
    end

    // DEPTH is a power of two, so the subtraction wraps modulo DEPTH.
    assign w_rd_slot  = r_wr_ptr - IDX_W'(1) - i_rd_age;
    assign o_rd_data  = r_mem[w_rd_slot];
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/rx_display_scheduler.sv
// Display scheduler: captures each rx_ready rising edge into the history
// buffer and rotates the hex display over stored bytes, newest first.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_EMPTY  | nothing stored; display blanked, dwell counter at 0
//   ST_SHOW   | rotating; dwell counter runs, index steps to older
//   ST_FROZEN | hold active; counter and index frozen, display on
module rx_display_scheduler
    import rx_display_scheduler_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int DWELL_CYCLES = DWELL_50MHZ,
    parameter int CNT_W        = 26
) (
    input  logic                     CLK_50M,
    input  logic                     reset_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_ready,
    input  logic                     hold,
    input  logic                     clear,
    output logic [7:0]               disp_value,
    output logic                     disp_enable,
    output logic [$clog2(DEPTH)-1:0] disp_index,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int               IDX_W      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    disp_state_e      r_state;
    logic             r_rx_ready_q;
    logic [CNT_W-1:0] r_dwell_cnt;
    logic [IDX_W-1:0] r_disp_index;
    logic             r_disp_enable;
    logic [7:0]       r_disp_value;

    logic             w_capture;
    logic             w_wr_en;
    logic [7:0]       w_rd_data;
    logic [IDX_W:0]   w_count;
    logic             w_overflow;
    logic [IDX_W:0]   w_idx_inc;
    logic [IDX_W-1:0] w_idx_next;

    // The edge detector keeps tracking rx_ready during clear so that a level
    // still high when clear drops does not look like a fresh byte.
    always_ff @(posedge CLK_50M or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_ready_q <= 1'b0;
        end else begin
            r_rx_ready_q <= rx_ready;
        end
    end

    assign w_capture = rx_ready & ~r_rx_ready_q;
    assign w_wr_en   = w_capture & ~clear;

    rx_history_buf #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_hist (
        .i_clk_sys  (CLK_50M),
        .i_rst_n    (reset_n),
        .i_clear    (clear),
        .i_wr_en    (w_wr_en),
        .i_wr_data  (rx_data),
        .i_rd_age   (r_disp_index),
        .o_rd_data  (w_rd_data),
        .o_count    (w_count),
        .o_overflow (w_overflow)
    );

    // Rotation wraps at the number of valid entries, not at DEPTH.
    assign w_idx_inc  = {1'b0, r_disp_index} + (IDX_W+1)'(1);
    assign w_idx_next = (w_idx_inc >= w_count) ? '0 : w_idx_inc[IDX_W-1:0];

    always_ff @(posedge CLK_50M or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_EMPTY;
            r_dwell_cnt   <= '0;
            r_disp_index  <= '0;
            r_disp_enable <= 1'b0;
        end else if (clear) begin
            r_state       <= ST_EMPTY;
            r_dwell_cnt   <= '0;
            r_disp_index  <= '0;
            r_disp_enable <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    r_dwell_cnt   <= '0;
                    r_disp_enable <= 1'b0;
                    if (w_wr_en) begin
                        r_disp_index  <= '0;
                        r_disp_enable <= 1'b1;
                        r_state       <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    r_disp_enable <= 1'b1;
                    if (w_wr_en) begin
                        r_disp_index <= '0;
                        r_dwell_cnt  <= '0;
                        r_state      <= hold ? ST_FROZEN : ST_SHOW;
                    end else if (hold) begin
                        r_state <= ST_FROZEN;
                    end else if (r_dwell_cnt == DWELL_LAST) begin
                        r_dwell_cnt  <= '0;
                        r_disp_index <= w_idx_next;
                    end else begin
                        r_dwell_cnt <= r_dwell_cnt + CNT_W'(1);
                    end
                end
                ST_FROZEN: begin
                    r_disp_enable <= 1'b1;
                    if (!hold) begin
                        r_state <= ST_SHOW;
                    end
                end
                default: begin
                    r_state       <= ST_EMPTY;
                    r_dwell_cnt   <= '0;
                    r_disp_index  <= '0;
                    r_disp_enable <= 1'b0;
                end
            endcase
        end
    end

    // One cycle behind any pointer/index change; blank while nothing is stored.
    always_ff @(posedge CLK_50M or negedge reset_n) begin
        if (!reset_n) begin
            r_disp_value <= SEG_BLANK;
        end else if (clear || (w_count == '0)) begin
            r_disp_value <= SEG_BLANK;
        end else begin
            r_disp_value <= w_rd_data;
        end
    end

    assign disp_value  = r_disp_value;
    assign disp_enable = r_disp_enable;
    assign disp_index  = r_disp_index;
    assign count       = w_count;
    assign overflow    = w_overflow;

endmodule

// File: doc/rx_display_scheduler.md
Name: rx_display_scheduler

Overview:
- Sequences the two-digit hex display of the IrDA receive path.
- Sits between RX_CONTROLLER (Dout/ready) and HEX_DISPLAY (value/enable).
- Captures each received byte into a small circular history buffer and time-multiplexes the display across stored bytes with a fixed dwell per byte.
- Supports freeze (hold) and clear from switches.

Parameters:
- DEPTH, 4, number of history entries; power of two, 2..16.
- DWELL_CYCLES, 50000000, clock cycles each entry is shown (1 s at 50 MHz); must be >= 2.
- CNT_W, 26, dwell counter width; must satisfy 2^CNT_W > DWELL_CYCLES.

Ports:
- CLK_50M  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte, from RX_CONTROLLER Dout.
- rx_ready  in  1  level-valid flag from RX_CONTROLLER; data is valid while high.
- hold  in  1  freeze rotation; synchronous level.
- clear  in  1  flush history; synchronous level.
- disp_value  out  8  byte to HEX_DISPLAY value.
- disp_enable  out  1  to HEX_DISPLAY enable; 0 blanks the digits.
- disp_index  out  log2(DEPTH)  age of shown entry: 0 = newest.
- count  out  log2(DEPTH)+1  number of valid entries, 0..DEPTH.
- overflow  out  1  sticky flag: a byte overwrote an unread-wrapped entry.

Behaviour:
- Reset (async assert; deassert sampled on CLK_50M). All outputs are 0: disp_value=0x00, disp_enable=0, disp_index=0, count=0, overflow=0. Buffer contents are don't-care. FSM=EMPTY.
- Capture:
  - Rising edge of rx_ready, detected as a registered previous value, creates a capture strobe in the same cycle rx_ready is first seen high.
  - rx_data is written at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
  - count saturates at DEPTH.
  - A capture while count==DEPTH overwrites the oldest entry and sets overflow.
  - A level that stays high never captures twice.
- FSM states:
  - EMPTY: disp_enable=0, dwell counter held at 0. On capture -> SHOW.
  - SHOW: disp_enable=1. The dwell counter increments each cycle.
    - At DWELL_CYCLES-1 the counter resets to 0 and disp_index advances toward older entries: (disp_index+1) mod count.
    - hold=1 -> FROZEN.
  - FROZEN: disp_enable=1, counter and disp_index frozen. hold=0 -> SHOW; the counter resumes from its frozen value.
- New byte while in SHOW: disp_index forced to 0 (newest) and dwell counter reset to 0 on the cycle after capture.
- New byte while in FROZEN: buffer updates and disp_index is held. The shown entry's age shifts by one because ages are relative to wr_ptr. disp_value therefore shows the entry at the same age, which may now be a different byte. This is intended.
- disp_value is registered. It is the buffer entry at (wr_ptr-1-disp_index) mod DEPTH and is updated one cycle after any pointer or index change. Latency from capture edge to disp_value showing the new byte is 2 cycles.
- clear=1 (any state):
  - Next cycle: count=0, wr_ptr=0, disp_index=0, overflow=0, disp_enable=0, disp_value=0x00, FSM=EMPTY.
  - clear has priority over a simultaneous capture; that byte is dropped.
  - The edge detector still records rx_ready, so no phantom capture follows after clear deasserts.
- Simultaneous hold and capture in SHOW: capture is stored, disp_index forced to 0, FSM -> FROZEN.
- Wrap-around: with count<DEPTH, rotation cycles only over valid entries (0..count-1). It never displays unwritten slots.
- Reset asserted mid-dwell or mid-capture: immediate return to reset values; a partially observed rx_ready edge is lost.

Decomposition:
- Shared package: FSM state encoding (EMPTY, SHOW, FROZEN), blank segment constant, default DWELL_CYCLES for 50 MHz.
- Sub-module rx_history_buf: circular byte buffer with write strobe, wr_ptr, count, overflow, and age-indexed read port.
- The scheduler FSM, dwell counter and edge detector stay in the top.

Test Plan (DEPTH=4, DWELL_CYCLES=4):
- Reset, no rx_ready: disp_enable=0, count=0, disp_value=0x00 for 20 cycles.
- Single byte 0xA5 with rx_ready held high 10 cycles: exactly one capture, count=1, disp_value=0xA5 two cycles after edge, disp_index stays 0 through rotations.
- Bytes 0x11,0x22,0x33 then idle: disp_value sequence 0x33,0x22,0x11,0x33, each held 4 cycles.
- Five bytes 0x01..0x05: count=4, overflow=1, rotation shows 0x05,0x04,0x03,0x02; 0x01 never appears.
- hold=1 while 0x22 is shown: disp_value stays 0x22 for 20 cycles. After release, dwell completes its remaining cycles, then 0x11 is shown.
- clear asserted on the same cycle as the rx_ready edge of 0x77: next cycle count=0, disp_enable=0, overflow=0. 0x77 is never displayed.
